// File: rtl/hms_clock_core.sv
// hms_clock_core: HH:MM:SS time-of-day core with 1 Hz prescaler, set-mode FSM,
// per-field up/down adjust, 12/24-hour display and set-mode blink.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   mode_btn     debounced level; rising edge steps RUN->SET_H->SET_M->SET_S->RUN
//   up_btn       debounced level; rising edge increments the selected field
//   down_btn     debounced level; rising edge decrements the selected field
//   fmt12        1 = 12-hour display, 0 = 24-hour display
//   bcd_out      {H1,H0,M1,M0,S1,S0} BCD digits, registered
//   digit_blank  per-digit blank (bit5=H1 .. bit0=S0), registered
//   pm           internal hour >= 12, registered
//   state        0=RUN, 1=SET_H, 2=SET_M, 3=SET_S
//   tick         one-cycle pulse on each time advance
//   day_wrap     one-cycle pulse when 23:59:59 rolls to 00:00:00
module hms_clock_core #(
  parameter int unsigned CLK_HZ   = 50000000,
  parameter int unsigned TICK_HZ  = 1,
  parameter int unsigned BLINK_HZ = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mode_btn,
  input  logic        up_btn,
  input  logic        down_btn,
  input  logic        fmt12,
  output logic [23:0] bcd_out,
  output logic [5:0]  digit_blank,
  output logic        pm,
  output logic [1:0]  state,
  output logic        tick,
  output logic        day_wrap
);

  localparam int unsigned DIV  = CLK_HZ / TICK_HZ;
  localparam int unsigned HALF = CLK_HZ / (2 * BLINK_HZ);
  localparam int unsigned PW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned BW   = (2 * HALF > 1) ? $clog2(2 * HALF) : 1;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_SET_H = 2'd1,
    ST_SET_M = 2'd2,
    ST_SET_S = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [BW-1:0]   blink_q, blink_d;
  logic [4:0]      hour_q, hour_d;
  logic [5:0]      min_q, min_d;
  logic [5:0]      sec_q, sec_d;
  logic            tick_q, tick_d;
  logic            day_wrap_q, day_wrap_d;
  logic [23:0]     bcd_q, bcd_d;
  logic [5:0]      blank_q, blank_d;
  logic            pm_q, pm_d;

  // Button synchronising stage (cur) and previous sample (prev) for edge detection
  logic mode_cur_q, mode_cur_d, mode_prev_q, mode_prev_d;
  logic up_cur_q, up_cur_d, up_prev_q, up_prev_d;
  logic dn_cur_q, dn_cur_d, dn_prev_q, dn_prev_d;

  logic mode_edge_c, up_edge_c, dn_edge_c, inc_c, dec_c;
  logic [4:0] disp_hour_c;

  // Binary 0..59 to two BCD digits
  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    logic [5:0] t;
    logic [5:0] o;
    t = v / 6'd10;
    o = v - (t * 6'd10);
    return {4'(t), 4'(o)};
  endfunction

  assign mode_edge_c = mode_cur_q & ~mode_prev_q;
  assign up_edge_c   = up_cur_q & ~up_prev_q;
  assign dn_edge_c   = dn_cur_q & ~dn_prev_q;
  // Simultaneous up and down cancel
  assign inc_c       = up_edge_c & ~dn_edge_c;
  assign dec_c       = dn_edge_c & ~up_edge_c;

  // Next-state: FSM, prescaler, time counters, blink counter
  always_comb begin
    state_d     = state_q;
    presc_d     = presc_q;
    blink_d     = blink_q;
    hour_d      = hour_q;
    min_d       = min_q;
    sec_d       = sec_q;
    tick_d      = 1'b0;
    day_wrap_d  = 1'b0;
    mode_cur_d  = mode_btn;
    mode_prev_d = mode_cur_q;
    up_cur_d    = up_btn;
    up_prev_d   = up_cur_q;
    dn_cur_d    = down_btn;
    dn_prev_d   = dn_cur_q;

    if (state_q == ST_RUN) begin
      blink_d = '0;
      if (presc_q == PW'(DIV - 1)) begin
        presc_d = '0;
        tick_d  = 1'b1;
        if (sec_q == 6'd59) begin
          sec_d = '0;
          if (min_q == 6'd59) begin
            min_d = '0;
            if (hour_q == 5'd23) begin
              hour_d     = '0;
              day_wrap_d = 1'b1;
            end else begin
              hour_d = hour_q + 5'd1;
            end
          end else begin
            min_d = min_q + 6'd1;
          end
        end else begin
          sec_d = sec_q + 6'd1;
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end else begin
      presc_d = '0;
      blink_d = (blink_q == BW'(2 * HALF - 1)) ? '0 : blink_q + BW'(1);
      // Field-local wrap, no carry between fields
      case (state_q)
        ST_SET_H: begin
          if (inc_c)      hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
          else if (dec_c) hour_d = (hour_q == 5'd0) ? 5'd23 : hour_q - 5'd1;
        end
        ST_SET_M: begin
          if (inc_c)      min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
          else if (dec_c) min_d = (min_q == 6'd0) ? 6'd59 : min_q - 6'd1;
        end
        ST_SET_S: begin
          if (inc_c)      sec_d = (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;
          else if (dec_c) sec_d = (sec_q == 6'd0) ? 6'd59 : sec_q - 6'd1;
        end
        default: ;
      endcase
    end

    // Restart blink phase so the edited field is visible right after an action
    if (mode_edge_c || up_edge_c || dn_edge_c) blink_d = '0;

    if (mode_edge_c) begin
      case (state_q)
        ST_RUN:   state_d = ST_SET_H;
        ST_SET_H: state_d = ST_SET_M;
        ST_SET_M: state_d = ST_SET_S;
        default:  state_d = ST_RUN;
      endcase
    end
  end

  // Display formatting: 12/24-hour, BCD, pm, blanking of the selected field
  always_comb begin
    disp_hour_c = hour_q;
    if (fmt12) begin
      if (hour_q == 5'd0)       disp_hour_c = 5'd12;
      else if (hour_q > 5'd12)  disp_hour_c = hour_q - 5'd12;
    end
    bcd_d   = {to_bcd(6'(disp_hour_c)), to_bcd(min_q), to_bcd(sec_q)};
    pm_d    = (hour_q >= 5'd12);
    blank_d = '0;
    if (blink_q >= BW'(HALF)) begin
      case (state_q)
        ST_SET_H: blank_d = 6'b110000;
        ST_SET_M: blank_d = 6'b001100;
        ST_SET_S: blank_d = 6'b000011;
        default:  blank_d = '0;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RUN;
      presc_q     <= '0;
      blink_q     <= '0;
      hour_q      <= '0;
      min_q       <= '0;
      sec_q       <= '0;
      tick_q      <= 1'b0;
      day_wrap_q  <= 1'b0;
      bcd_q       <= '0;
      blank_q     <= '0;
      pm_q        <= 1'b0;
      mode_cur_q  <= 1'b0;
      mode_prev_q <= 1'b0;
      up_cur_q    <= 1'b0;
      up_prev_q   <= 1'b0;
      dn_cur_q    <= 1'b0;
      dn_prev_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      blink_q     <= blink_d;
      hour_q      <= hour_d;
      min_q       <= min_d;
      sec_q       <= sec_d;
      tick_q      <= tick_d;
      day_wrap_q  <= day_wrap_d;
      bcd_q       <= bcd_d;
      blank_q     <= blank_d;
      pm_q        <= pm_d;
      mode_cur_q  <= mode_cur_d;
      mode_prev_q <= mode_prev_d;
      up_cur_q    <= up_cur_d;
      up_prev_q   <= up_prev_d;
      dn_cur_q    <= dn_cur_d;
      dn_prev_q   <= dn_prev_d;
    end
  end

  assign bcd_out     = bcd_q;
  assign digit_blank = blank_q;
  assign pm          = pm_q;
  assign state       = state_q;
  assign tick        = tick_q;
  assign day_wrap    = day_wrap_q;

endmodule
